// File: rtl/mips_load_store_unit.sv
// Load/store unit between a MIPS pipeline and a word-wide data memory.
// Handles byte/half/word accesses, sub-word stores by read-modify-write, and alignment errors.
module mips_load_store_unit #(
  parameter int Data_Width          = 32,
  parameter int Data_Mem_Addr_Width = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_we,
  input  logic [1:0]                     req_size,
  input  logic                           req_unsigned,
  input  logic [Data_Mem_Addr_Width+1:0] req_addr,
  input  logic [Data_Width-1:0]          req_wdata,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [Data_Width-1:0]          rsp_data,
  output logic                           rsp_err,
  output logic                           mem_we,
  output logic [Data_Mem_Addr_Width-1:0] mem_addr,
  output logic [Data_Width-1:0]          mem_wdata,
  input  logic [Data_Width-1:0]          mem_rdata
);

  localparam int NL = Data_Width / 8;

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

  state_t                         state_q, state_d;
  logic                           we_q, we_d;
  logic [1:0]                     size_q, size_d;
  logic                           unsigned_q, unsigned_d;
  logic [Data_Mem_Addr_Width+1:0] addr_q, addr_d;
  logic [Data_Width-1:0]          wdata_q, wdata_d;
  logic [Data_Width-1:0]          word_q, word_d;
  logic [Data_Width-1:0]          rsp_data_q, rsp_data_d;
  logic                           rsp_err_q, rsp_err_d;

  logic                           misaligned;
  logic                           word_store;
  logic [7:0]                     byte_sel;
  logic [15:0]                    half_sel;
  logic [Data_Width-1:0]          load_ext;
  logic [NL-1:0]                  lane_mask;
  logic [Data_Width-1:0]          merged_word;

  assign misaligned = (size_q == 2'b11) ||
                      ((size_q == 2'b01) && addr_q[0]) ||
                      ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
  assign word_store = we_q && (size_q == 2'b10) && !misaligned;

  // Little-endian lane pick: byte offset selects bits [8*off+7:8*off].
  assign byte_sel = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign half_sel = mem_rdata[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    load_ext = mem_rdata;
    case (size_q)
      2'b00:   load_ext = {{(Data_Width-8){~unsigned_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{(Data_Width-16){~unsigned_q & half_sel[15]}}, half_sel};
      default: load_ext = mem_rdata;
    endcase
  end

  // Read-modify-write merge: replace only the addressed byte lanes of the latched word.
  generate
    for (genvar gi = 0; gi < NL; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi % 4);
      assign lane_mask[gi] = (size_q == 2'b00) ? (addr_q[1:0] == LANE)
                                               : (addr_q[1] == LANE[1]);
      assign merged_word[gi*8 +: 8] =
        !lane_mask[gi]     ? word_q[gi*8 +: 8] :
        (size_q == 2'b00)  ? wdata_q[7:0] :
        LANE[0]            ? wdata_q[15:8] : wdata_q[7:0];
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    word_d     = word_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d       = req_we;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        if (misaligned) begin
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          state_d    = RESP;
        end else if (!we_q) begin
          rsp_data_d = load_ext;
          state_d    = RESP;
        end else if (size_q == 2'b10) begin
          state_d    = RESP;
        end else begin
          word_d     = mem_rdata;
          state_d    = MERGE;
        end
      end
      MERGE:   state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write strobes depend only on state and captured fields, never on live request inputs.
  always_comb begin
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state_q)
      ACCESS: begin
        if (word_store) begin
          mem_we    = 1'b1;
          mem_wdata = wdata_q;
        end
      end
      MERGE: begin
        mem_we    = 1'b1;
        mem_wdata = merged_word;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      word_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      word_q     <= word_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign mem_addr  = addr_q[Data_Mem_Addr_Width+1:2];

endmodule

// File: tb/tb_mips_load_store_unit.sv
// Directed bench for mips_load_store_unit with a behavioural word memory.
module tb_mips_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] mem [0:255];
  logic        load_en;
  logic [7:0]  load_addr;
  logic [31:0] load_data;
  int          we_pulses = 0;
  int          checks = 0;
  int          failures = 0;
  int          p0;

  always #5 clk = ~clk;

  mips_load_store_unit #(.Data_Width(32), .Data_Mem_Addr_Width(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
    else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      we_pulses     <= we_pulses + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single accept edge; returns #1 into the ACCESS cycle.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [9:0] addr, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    tick();
    req_valid    = 1'b0;
    $display("REQ we=%0b size=%b uns=%0b addr=%h wdata=%h", we, size, uns, addr, wdata);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_data"},  rsp_data,  0);
    check({tag, "_rsp_err"},   rsp_err,   0);
    check({tag, "_mem_we"},    mem_we,    0);
    check({tag, "_mem_addr"},  mem_addr,  0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0; rsp_ready = 1'b1;
    load_en = 1'b1; load_addr = 8'd4; load_data = 32'h8899AABB;
    #1;
    check_reset_outputs("reset");
    tick();
    load_en = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Signed byte load from lane 3
    issue(0, 2'b00, 0, 10'h013, 0);
    check("lb_access_ready", req_ready, 0);
    check("lb_access_we", mem_we, 0);
    check("lb_access_addr", mem_addr, 4);
    check("lb_access_valid", rsp_valid, 0);
    tick();
    check("lb_valid", rsp_valid, 1);
    check("lb_data", rsp_data, 32'hFFFFFF88);
    check("lb_err", rsp_err, 0);
    tick();
    check("lb_idle_ready", req_ready, 1);
    check("lb_idle_valid", rsp_valid, 0);

    issue(0, 2'b00, 1, 10'h013, 0);
    tick();
    check("lbu_data", rsp_data, 32'h00000088);
    tick();

    // Half store through read-modify-write
    p0 = we_pulses;
    issue(1, 2'b01, 0, 10'h012, 32'hDEAD1234);
    check("sh_access_we", mem_we, 0);
    tick();
    check("sh_merge_we", mem_we, 1);
    check("sh_merge_wdata", mem_wdata, 32'h1234AABB);
    check("sh_merge_valid", rsp_valid, 0);
    tick();
    check("sh_valid", rsp_valid, 1);
    check("sh_data", rsp_data, 0);
    check("sh_resp_we", mem_we, 0);
    check("sh_mem4", mem[4], 32'h1234AABB);
    check("sh_pulses", we_pulses - p0, 1);
    tick();

    // Misaligned word store
    p0 = we_pulses;
    issue(1, 2'b10, 0, 10'h011, 32'hCAFEF00D);
    check("swmis_access_we", mem_we, 0);
    tick();
    check("swmis_valid", rsp_valid, 1);
    check("swmis_err", rsp_err, 1);
    check("swmis_data", rsp_data, 0);
    tick();
    check("swmis_pulses", we_pulses - p0, 0);
    check("swmis_mem4", mem[4], 32'h1234AABB);

    issue(0, 2'b01, 0, 10'h012, 0);
    tick();
    check("lh_hi_data", rsp_data, 32'h00001234);
    check("lh_hi_err", rsp_err, 0);
    tick();
    issue(0, 2'b01, 0, 10'h010, 0);
    tick();
    check("lh_lo_data", rsp_data, 32'hFFFFAABB);
    tick();
    issue(0, 2'b01, 1, 10'h010, 0);
    tick();
    check("lhu_lo_data", rsp_data, 32'h0000AABB);
    tick();

    // Aligned word store writes straight from ACCESS
    issue(1, 2'b10, 0, 10'h014, 32'hCAFEF00D);
    check("sw_access_we", mem_we, 1);
    check("sw_access_wdata", mem_wdata, 32'hCAFEF00D);
    check("sw_access_addr", mem_addr, 5);
    tick();
    check("sw_valid", rsp_valid, 1);
    check("sw_err", rsp_err, 0);
    check("sw_resp_we", mem_we, 0);
    check("sw_resp_wdata", mem_wdata, 0);
    check("sw_mem5", mem[5], 32'hCAFEF00D);
    tick();

    issue(0, 2'b10, 0, 10'h014, 0);
    tick();
    check("lw_data", rsp_data, 32'hCAFEF00D);
    tick();
    issue(0, 2'b11, 0, 10'h014, 0);
    tick();
    check("ill_err", rsp_err, 1);
    check("ill_data", rsp_data, 0);
    tick();

    // Response back-pressure with a competing request
    p0 = we_pulses;
    rsp_ready = 1'b0;
    issue(0, 2'b00, 1, 10'h013, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h020;
      check("bp_valid", rsp_valid, 1);
      check("bp_data", rsp_data, 32'h00000012);
      check("bp_ready", req_ready, 0);
      check("bp_addr", mem_addr, 4);
      tick();
    end
    req_valid = 1'b0; req_we = 1'b0;
    rsp_ready = 1'b1;
    check("bp_release_valid", rsp_valid, 1);
    check("bp_release_data", rsp_data, 32'h00000012);
    tick();
    check("bp_idle_ready", req_ready, 1);
    check("bp_idle_valid", rsp_valid, 0);
    check("bp_idle_addr", mem_addr, 4);
    check("bp_pulses", we_pulses - p0, 0);

    // Reset asserted mid-MERGE of a byte store
    p0 = we_pulses;
    issue(1, 2'b00, 0, 10'h014, 32'h00000077);
    tick();
    check("rstm_merge_we", mem_we, 1);
    check("rstm_merge_wdata", mem_wdata, 32'hCAFEF077);
    rst = 1'b1;
    #1;
    check_reset_outputs("rstm");
    tick();
    check("rstm_mem5", mem[5], 32'hCAFEF00D);
    check("rstm_pulses", we_pulses - p0, 0);
    rst = 1'b0;
    tick();

    issue(1, 2'b00, 0, 10'h014, 32'h00000077);
    tick();
    tick();
    check("sb_valid", rsp_valid, 1);
    check("sb_mem5", mem[5], 32'hCAFEF077);
    tick();
    issue(0, 2'b00, 0, 10'h015, 0);
    tick();
    check("lb_after_rst", rsp_data, 32'hFFFFFFF0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
